// File: rtl/tcdm_init_pkg.sv
// Shared types for the TCDM bank init front-end: engine state encoding and the
// word-address width helper.
package tcdm_init_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StVerify,
      StDone
   } state_e;

   function automatic int unsigned addr_width(input int unsigned bank_size);
      return $clog2(bank_size);
   endfunction

endpackage

// File: rtl/tcdm_bank_init_arb_if.sv
// Interconnect-side TCDM slave port of one bank: request/grant plus the
// read-response channel.
interface tcdm_bank_init_arb_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                      req;
   logic                      wen;
   logic [31:0]               add;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   be;
   logic                      gnt;
   logic [DATA_WIDTH-1:0]     r_data;
   logic                      r_valid;

   modport master (
      output req, wen, add, wdata, be,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, wen, add, wdata, be,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/tcdm_init_ctrl.sv
// Init sweep engine: FSM, word counter and busy/done (and, with
// TCDM_INIT_VERIFY_EN, read-back verify with a sticky error flag).
module tcdm_init_ctrl
   import tcdm_init_pkg::*;
#(
   parameter int unsigned  BANK_SIZE = 256,
   localparam int unsigned AW        = addr_width(BANK_SIZE)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          init_start_i,
`ifdef TCDM_INIT_VERIFY_EN
   input  logic          rd_mismatch_i,
   output logic          init_error_o,
`endif
   output logic          eng_req_o,
   output logic          eng_we_o,
   output logic [AW-1:0] eng_addr_o,
   output logic          init_busy_o,
   output logic          init_done_o
);

   localparam logic [AW-1:0] LastAddr = AW'(BANK_SIZE - 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;

`ifdef TCDM_INIT_VERIFY_EN
   // tail: last read issued, one compare cycle left; rd_pend: read issued last cycle
   logic tail_q, tail_d;
   logic rd_pend_q, rd_pend_d;
   logic err_q, err_d;

   assign init_error_o = err_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
`ifdef TCDM_INIT_VERIFY_EN
         tail_q    <= 1'b0;
         rd_pend_q <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
`ifdef TCDM_INIT_VERIFY_EN
         tail_q    <= tail_d;
         rd_pend_q <= rd_pend_d;
         err_q     <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      eng_req_o = 1'b0;
      eng_we_o  = 1'b0;
`ifdef TCDM_INIT_VERIFY_EN
      tail_d    = tail_q;
      rd_pend_d = 1'b0;
      err_d     = err_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (init_start_i) begin
               state_d = StFill;
               cnt_d   = '0;
`ifdef TCDM_INIT_VERIFY_EN
               err_d   = 1'b0;
`endif
            end
         end
         StFill: begin
            eng_req_o = 1'b1;
            eng_we_o  = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
`ifdef TCDM_INIT_VERIFY_EN
               state_d = StVerify;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef TCDM_INIT_VERIFY_EN
         StVerify: begin
            if (rd_pend_q && rd_mismatch_i) err_d = 1'b1;
            if (tail_q) begin
               state_d = StDone;
               tail_d  = 1'b0;
            end else begin
               eng_req_o = 1'b1;
               rd_pend_d = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LastAddr) tail_d = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   assign eng_addr_o  = cnt_q;
   assign init_busy_o = (state_q == StFill) || (state_q == StVerify);
   assign init_done_o = (state_q == StDone);

endmodule

// File: rtl/tcdm_bank_init_arb.sv
// Per-bank TCDM front-end: muxes the bank port between the interconnect and the
// init sweep engine and generates r_valid. Option macro: TCDM_INIT_VERIFY_EN.
module tcdm_bank_init_arb
   import tcdm_init_pkg::*;
#(
   parameter int unsigned          BANK_SIZE    = 256,
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = '0,
   localparam int unsigned         AW           = addr_width(BANK_SIZE)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     init_start_i,
   output logic                     init_busy_o,
   output logic                     init_done_o,
`ifdef TCDM_INIT_VERIFY_EN
   output logic                     init_error_o,
`endif
   tcdm_bank_init_arb_if.slave      slv,
   output logic                     bank_req_o,
   output logic                     bank_we_o,
   output logic [AW-1:0]            bank_addr_o,
   output logic [DATA_WIDTH-1:0]    bank_wdata_o,
   output logic [DATA_WIDTH/8-1:0]  bank_be_o,
   input  logic [DATA_WIDTH-1:0]    bank_rdata_i
);

   logic          eng_req, eng_we;
   logic [AW-1:0] eng_addr;
   logic          gnt;
   logic          r_valid_q, r_valid_d;
   logic          unused_add;

`ifdef TCDM_INIT_VERIFY_EN
   logic rd_mismatch;
   assign rd_mismatch = (bank_rdata_i != FILL_PATTERN);
`endif

   tcdm_init_ctrl #(
      .BANK_SIZE (BANK_SIZE)
   ) u_ctrl (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .init_start_i  (init_start_i),
`ifdef TCDM_INIT_VERIFY_EN
      .rd_mismatch_i (rd_mismatch),
      .init_error_o  (init_error_o),
`endif
      .eng_req_o     (eng_req),
      .eng_we_o      (eng_we),
      .eng_addr_o    (eng_addr),
      .init_busy_o   (init_busy_o),
      .init_done_o   (init_done_o)
   );

   // A start request takes the port in its own cycle, ahead of the interconnect.
   assign gnt = slv.req & ~init_busy_o & ~init_start_i;

   always_comb begin
      bank_req_o   = eng_req | gnt;
      bank_we_o    = ~slv.wen;
      bank_addr_o  = slv.add[AW+1:2];
      bank_wdata_o = slv.wdata;
      bank_be_o    = slv.be;
      if (eng_req) begin
         bank_we_o    = eng_we;
         bank_addr_o  = eng_addr;
         bank_wdata_o = FILL_PATTERN;
         bank_be_o    = '1;
      end
   end

   assign r_valid_d = gnt & slv.wen;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_valid_q <= 1'b0;
      else       r_valid_q <= r_valid_d;
   end

   assign slv.gnt     = gnt;
   assign slv.r_data  = bank_rdata_i;
   assign slv.r_valid = r_valid_q;

   assign unused_add = ^{slv.add[31:AW+2], slv.add[1:0]};

endmodule

// File: tb/tb_tcdm_bank_init_arb.sv
// Self-checking bench for tcdm_bank_init_arb: vector table for pass-through,
// scoreboard for read responses, hand sequences for the init sweep cases.
module tb_tcdm_bank_init_arb;

   localparam int unsigned BANK = 256;
   localparam int unsigned DW   = 32;
   localparam logic [31:0] FILL = 32'hA5C3_0F96;
   localparam logic [31:0] HOLD_ADD  = 32'h0000_0028;
   localparam logic [31:0] HOLD_DATA = 32'hDEAD_BEEF;
   localparam logic [3:0]  HOLD_BE   = 4'b0011;

   logic        clk;
   logic        rst;
   logic        init_start;
   logic        init_busy, init_done;
`ifdef TCDM_INIT_VERIFY_EN
   logic        init_error;
`endif
   logic        bank_req, bank_we;
   logic [7:0]  bank_addr;
   logic [31:0] bank_wdata;
   logic [3:0]  bank_be;
   logic [31:0] bank_rdata;

   tcdm_bank_init_arb_if #(.DATA_WIDTH(DW)) slv_if ();

   tcdm_bank_init_arb #(
      .BANK_SIZE    (BANK),
      .DATA_WIDTH   (DW),
      .FILL_PATTERN (FILL)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .init_start_i (init_start),
      .init_busy_o  (init_busy),
      .init_done_o  (init_done),
`ifdef TCDM_INIT_VERIFY_EN
      .init_error_o (init_error),
`endif
      .slv          (slv_if),
      .bank_req_o   (bank_req),
      .bank_we_o    (bank_we),
      .bank_addr_o  (bank_addr),
      .bank_wdata_o (bank_wdata),
      .bank_be_o    (bank_be),
      .bank_rdata_i (bank_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: 1-cycle read latency, byte enables, optional bit flip on one word.
   logic [31:0] mem [BANK];
   logic [31:0] ref_mem [BANK];
   bit          flip_en;
   logic [7:0]  flip_addr;

   always @(posedge clk) begin
      if (bank_req) begin
         if (bank_we) begin
            for (int b = 0; b < 4; b++)
               if (bank_be[b]) mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
         end else begin
            bank_rdata <= mem[bank_addr] ^ ((flip_en && bank_addr == flip_addr) ? 32'h1 : 32'h0);
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Scoreboard of expected read responses, each due on a specific cycle.
   typedef struct {
      logic [31:0] data;
      int          due;
   } sb_t;
   sb_t sb_q [$];

   always @(negedge clk) begin
      if (!rst) begin
         if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_rvalid", 32'(slv_if.r_valid), 32'd1);
            check("sb_rdata", slv_if.r_data, e.data);
         end else if (slv_if.r_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_spurious: r_valid got 1 expected 0 at cycle %0d", cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] add, input int idx);
      slv_if.req = 1'b1;
      slv_if.wen = 1'b1;
      slv_if.add = add;
      @(negedge clk);
      check("rd_gnt", 32'(slv_if.gnt), 32'd1);
      check("rd_addr", 32'(bank_addr), 32'(idx));
      sb_q.push_back('{data: ref_mem[idx], due: cyc + 1});
      step();
      slv_if.req = 1'b0;
   endtask

   // Entered at posedge+1 of the first FILL cycle; returns at negedge of the DONE cycle.
   task automatic run_sweep(input bit hold_wr, input int pulse_at);
      for (int i = 0; i < int'(BANK); i++) begin
         @(negedge clk);
         check("fill_req", 32'(bank_req), 32'd1);
         check("fill_we", 32'(bank_we), 32'd1);
         check("fill_addr", 32'(bank_addr), 32'(i));
         check("fill_wdata", bank_wdata, FILL);
         check("fill_be", 32'(bank_be), 32'hF);
         check("fill_gnt", 32'(slv_if.gnt), 32'd0);
         check("fill_busy", 32'(init_busy), 32'd1);
         check("fill_done", 32'(init_done), 32'd0);
         step();
         init_start = (i + 1 == pulse_at);
      end
`ifdef TCDM_INIT_VERIFY_EN
      for (int j = 0; j <= int'(BANK); j++) begin
         @(negedge clk);
         check("vfy_gnt", 32'(slv_if.gnt), 32'd0);
         check("vfy_busy", 32'(init_busy), 32'd1);
         if (j < int'(BANK)) begin
            check("vfy_req", 32'(bank_req), 32'd1);
            check("vfy_we", 32'(bank_we), 32'd0);
            check("vfy_addr", 32'(bank_addr), 32'(j));
         end else begin
            check("vfy_tail_req", 32'(bank_req), 32'd0);
         end
         step();
      end
`endif
      @(negedge clk);
      check("end_done", 32'(init_done), 32'd1);
      check("end_busy", 32'(init_busy), 32'd0);
      for (int k = 0; k < int'(BANK); k++) ref_mem[k] = FILL;
      if (hold_wr) begin
         check("held_gnt", 32'(slv_if.gnt), 32'd1);
         check("held_req", 32'(bank_req), 32'd1);
         check("held_we", 32'(bank_we), 32'd1);
         check("held_addr", 32'(bank_addr), 32'd10);
         check("held_be", 32'(bank_be), 32'(HOLD_BE));
         check("held_wdata", bank_wdata, HOLD_DATA);
         ref_mem[10] = merge(ref_mem[10], HOLD_DATA, HOLD_BE);
      end
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] add;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [7:0]  exp_addr;
      logic        exp_we;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0010, 32'h0,          4'hF, 8'd4,   1'b0};
      vecs[1] = '{1'b0, 32'h0000_0020, 32'h1234_5678,  4'hF, 8'd8,   1'b1};
      vecs[2] = '{1'b1, 32'h0000_0020, 32'h0,          4'hF, 8'd8,   1'b0};
      vecs[3] = '{1'b0, 32'h0000_0024, 32'hCAFE_F00D,  4'h5, 8'd9,   1'b1};
      vecs[4] = '{1'b1, 32'h0000_0027, 32'h0,          4'hF, 8'd9,   1'b0};
      vecs[5] = '{1'b0, 32'hFFFF_F3FC, 32'h0BAD_C0DE,  4'h8, 8'd255, 1'b1};
      vecs[6] = '{1'b1, 32'h0000_07FC, 32'h0,          4'hF, 8'd255, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_0403, 32'h0,          4'hF, 8'd0,   1'b0};
      vecs[8] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF,  4'h0, 8'd4,   1'b1};
      vecs[9] = '{1'b1, 32'h0000_0010, 32'h0,          4'hF, 8'd4,   1'b0};

      for (int i = 0; i < int'(BANK); i++) begin
         mem[i]     = init_val(i);
         ref_mem[i] = init_val(i);
      end
      flip_en      = 1'b0;
      flip_addr    = 8'd7;
      init_start   = 1'b0;
      slv_if.req   = 1'b0;
      slv_if.wen   = 1'b1;
      slv_if.add   = '0;
      slv_if.wdata = '0;
      slv_if.be    = '0;
      rst          = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_busy", 32'(init_busy), 32'd0);
      check("rst_done", 32'(init_done), 32'd0);
      check("rst_rvalid", 32'(slv_if.r_valid), 32'd0);
      check("rst_bank_req", 32'(bank_req), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         slv_if.req   = 1'b1;
         slv_if.wen   = vecs[k].wen;
         slv_if.add   = vecs[k].add;
         slv_if.wdata = vecs[k].wdata;
         slv_if.be    = vecs[k].be;
         @(negedge clk);
         check($sformatf("v%0d_gnt", k), 32'(slv_if.gnt), 32'd1);
         check($sformatf("v%0d_req", k), 32'(bank_req), 32'd1);
         check($sformatf("v%0d_we", k), 32'(bank_we), 32'(vecs[k].exp_we));
         check($sformatf("v%0d_addr", k), 32'(bank_addr), 32'(vecs[k].exp_addr));
         if (!vecs[k].wen) begin
            check($sformatf("v%0d_wdata", k), bank_wdata, vecs[k].wdata);
            check($sformatf("v%0d_be", k), 32'(bank_be), 32'(vecs[k].be));
            ref_mem[vecs[k].exp_addr] = merge(ref_mem[vecs[k].exp_addr], vecs[k].wdata,
                                              vecs[k].be);
         end else begin
            sb_q.push_back('{data: ref_mem[vecs[k].exp_addr], due: cyc + 1});
         end
         step();
      end
      slv_if.req = 1'b0;
      @(negedge clk);
      check("idle_bank_req", 32'(bank_req), 32'd0);
      check("idle_gnt", 32'(slv_if.gnt), 32'd0);

      // Sweep with a colliding read on the start cycle, a held write, and a re-start pulse.
      step();
      init_start = 1'b1;
      slv_if.req = 1'b1;
      slv_if.wen = 1'b1;
      slv_if.add = 32'h0000_0020;
      @(negedge clk);
      check("start_gnt", 32'(slv_if.gnt), 32'd0);
      check("start_busy", 32'(init_busy), 32'd0);
      step();
      init_start   = 1'b0;
      slv_if.wen   = 1'b0;
      slv_if.add   = HOLD_ADD;
      slv_if.wdata = HOLD_DATA;
      slv_if.be    = HOLD_BE;
      run_sweep(1'b1, 50);
`ifdef TCDM_INIT_VERIFY_EN
      check("sweep1_err", 32'(init_error), 32'd0);
`endif
      step();
      slv_if.req = 1'b0;
      do_read(32'h0000_0010, 4);
      do_read(HOLD_ADD, 10);
      do_read(32'h0000_03FC, 255);
      do_read(32'h0000_0000, 0);

      // Reset in the middle of a sweep, then a clean restart from word 0.
      step();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      repeat (100) step();
      @(negedge clk);
      check("mid_addr", 32'(bank_addr), 32'd100);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(init_busy), 32'd0);
      check("mid_rst_done", 32'(init_done), 32'd0);
      check("mid_rst_req", 32'(bank_req), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(init_busy), 32'd0);
      check("post_rst_done", 32'(init_done), 32'd0);
      step();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      run_sweep(1'b0, 0);
      step();
      do_read(HOLD_ADD, 10);
      do_read(32'h0000_01C0, 112);

`ifdef TCDM_INIT_VERIFY_EN
      flip_en = 1'b1;
      step();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      run_sweep(1'b0, 0);
      check("vfy_err_set", 32'(init_error), 32'd1);
      step();
      step();
      @(negedge clk);
      check("vfy_err_sticky", 32'(init_error), 32'd1);
      check("vfy_done_sticky", 32'(init_done), 32'd1);
      flip_en = 1'b0;
      step();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      run_sweep(1'b0, 0);
      check("vfy_err_clear", 32'(init_error), 32'd0);
`endif

      step();
      step();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
